eeprom_seq: RTL

EEPROM_SEQ -- requirements
Module: eeprom_seq

---
 rtl/eeprom_seq_if.sv | 11 +
 rtl/eeprom_seq.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/eeprom_seq_if.sv
// Request/acknowledge bus between the burst sequencer and the EEPROM serial master.
// The parallel DATA byte is bidirectional, so it travels as a plain inout port on the sequencer.
interface eeprom_seq_if;
  logic        WR;
  logic        RD;
  logic [10:0] ADDR;
  logic        ACK;

  modport master (output WR, output RD, output ADDR, input ACK);
  modport slave  (input WR, input RD, input ADDR, output ACK);
endinterface

// File: rtl/eeprom_seq.sv
// Write-then-verify burst sequencer for an EEPROM serial master: writes SEED+i to BASE_ADDR+i,
// waits out the internal write time, then reads every byte back and counts mismatches.
module eeprom_seq #(
  parameter int WR_GAP  = 16,
  parameter int TIMEOUT = 4095
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         START,
  input  logic [10:0]  BASE_ADDR,
  input  logic [7:0]   LEN,
  input  logic [7:0]   SEED,
  eeprom_seq_if.master bus,
  inout  wire  [7:0]   DATA,
  output logic         BUSY,
  output logic         DONE,
  output logic         ERR,
  output logic         TMO,
  output logic [7:0]   ERR_CNT,
  output logic [10:0]  FAIL_ADDR
);

  typedef enum logic [6:0] {
    IDLE   = 7'b0000001,
    W_REQ  = 7'b0000010,
    W_WAIT = 7'b0000100,
    W_GAP  = 7'b0001000,
    R_REQ  = 7'b0010000,
    R_WAIT = 7'b0100000,
    FINISH = 7'b1000000
  } state_t;

  localparam logic [11:0] TMO_LAST = 12'(TIMEOUT - 1);
  localparam logic [15:0] GAP_LOAD = 16'(WR_GAP);

  state_t      state;
  logic        wr_q;
  logic        rd_q;
  logic [10:0] addr_q;
  logic [10:0] base_q;
  logic [7:0]  seed_q;
  logic [7:0]  last_q;
  logic [7:0]  idx;
  logic [7:0]  pattern;
  logic [11:0] tmo_cnt;
  logic [15:0] gap_cnt;

  logic [7:0]  idx_next;
  logic [10:0] addr_next;
  logic        tmo_hit;

  assign idx_next  = idx + 8'd1;
  assign addr_next = base_q + {3'b000, idx_next};
  assign tmo_hit   = (tmo_cnt == TMO_LAST);

  assign bus.WR   = wr_q;
  assign bus.RD   = rd_q;
  assign bus.ADDR = addr_q;

  // pattern always holds SEED+idx: the byte to write, and later the byte expected back
  assign DATA = wr_q ? pattern : 8'hzz;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= IDLE;
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      addr_q    <= '0;
      base_q    <= '0;
      seed_q    <= '0;
      last_q    <= '0;
      idx       <= '0;
      pattern   <= '0;
      tmo_cnt   <= '0;
      gap_cnt   <= '0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      ERR       <= 1'b0;
      TMO       <= 1'b0;
      ERR_CNT   <= '0;
      FAIL_ADDR <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (START) begin
            base_q    <= BASE_ADDR;
            seed_q    <= SEED;
            last_q    <= LEN - 8'd1;
            idx       <= '0;
            pattern   <= SEED;
            addr_q    <= BASE_ADDR;
            ERR       <= 1'b0;
            TMO       <= 1'b0;
            ERR_CNT   <= '0;
            FAIL_ADDR <= '0;
            BUSY      <= 1'b1;
            tmo_cnt   <= '0;
            wr_q      <= 1'b1;
            state     <= W_REQ;
          end
        end

        W_REQ: begin
          if (bus.ACK) begin
            wr_q  <= 1'b0;
            state <= W_WAIT;
          end else if (tmo_hit) begin
            wr_q  <= 1'b0;
            TMO   <= 1'b1;
            ERR   <= 1'b1;
            DONE  <= 1'b1;
            state <= FINISH;
          end else begin
            tmo_cnt <= tmo_cnt + 12'd1;
          end
        end

        W_WAIT: begin
          if (!bus.ACK) begin
            gap_cnt <= GAP_LOAD;
            state   <= W_GAP;
          end
        end

        // gap expired: either the next write, or restart at byte 0 for the readback pass
        W_GAP: begin
          if (gap_cnt != 16'd0) begin
            gap_cnt <= gap_cnt - 16'd1;
          end else begin
            tmo_cnt <= '0;
            if (idx == last_q) begin
              idx     <= '0;
              pattern <= seed_q;
              addr_q  <= base_q;
              rd_q    <= 1'b1;
              state   <= R_REQ;
            end else begin
              idx     <= idx_next;
              pattern <= seed_q + idx_next;
              addr_q  <= addr_next;
              wr_q    <= 1'b1;
              state   <= W_REQ;
            end
          end
        end

        R_REQ: begin
          if (bus.ACK) begin
            rd_q  <= 1'b0;
            state <= R_WAIT;
            if (DATA != pattern) begin
              ERR <= 1'b1;
              if (ERR_CNT != 8'hFF) ERR_CNT <= ERR_CNT + 8'd1;
              if (ERR_CNT == 8'd0) FAIL_ADDR <= addr_q;
            end
          end else if (tmo_hit) begin
            rd_q  <= 1'b0;
            TMO   <= 1'b1;
            ERR   <= 1'b1;
            DONE  <= 1'b1;
            state <= FINISH;
          end else begin
            tmo_cnt <= tmo_cnt + 12'd1;
          end
        end

        R_WAIT: begin
          if (!bus.ACK) begin
            if (idx == last_q) begin
              DONE  <= 1'b1;
              state <= FINISH;
            end else begin
              idx     <= idx_next;
              pattern <= seed_q + idx_next;
              addr_q  <= addr_next;
              tmo_cnt <= '0;
              rd_q    <= 1'b1;
              state   <= R_REQ;
            end
          end
        end

        FINISH: begin
          DONE  <= 1'b0;
          BUSY  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
